// File: rtl/spi_reg_bank_gen.sv
// Register bank for the SPI master: CTRL, DIVIDER, SS and STATUS registers
// plus the TX/RX shift register, with auto slave-select and a sticky interrupt flag.
module spi_reg_bank_gen #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_SS = 8,
  parameter int unsigned ADDR_W = 8,
  localparam int unsigned CL_W = $clog2(DATA_W)
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  input  logic              transfer,
  input  logic              miso_pad_i,
  input  logic              sample_en,
  input  logic              transfer_en,
  input  logic              bsy_clr,
  output logic              ie,
  output logic              lsb,
  output logic              cpol,
  output logic              cpha,
  output logic              go_bsy,
  output logic              ass,
  output logic [CL_W-1:0]   char_len,
  output logic [15:0]       divider,
  output logic [DATA_W-1:0] trx,
  output logic [NUM_SS-1:0] ss_o,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] ADDR_TRX    = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(32'h10);
  localparam logic [ADDR_W-1:0] ADDR_DIV    = ADDR_W'(32'h14);
  localparam logic [ADDR_W-1:0] ADDR_SS     = ADDR_W'(32'h18);
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(32'h1C);

  logic [CL_W-1:0]   char_len_q, char_len_d;
  logic              go_bsy_q, go_bsy_d;
  logic              cpha_q, cpha_d;
  logic              cpol_q, cpol_d;
  logic              lsb_q, lsb_d;
  logic              ie_q, ie_d;
  logic              ass_q, ass_d;
  logic [15:0]       divider_q, divider_d;
  logic [NUM_SS-1:0] ss_q, ss_d;
  logic              int_flag_q, int_flag_d;
  logic [DATA_W-1:0] trx_q, trx_d;
  logic              q_miso_q, q_miso_d;

  logic              wr_ok;
  logic              wr_trx, wr_ctrl, wr_div, wr_ss;
  logic              st_clr;
  int unsigned       n_len;
  logic [DATA_W-1:0] shl, shr, trx_shift;

  always_comb begin
    wr_ok   = wr_en & ~transfer;
    wr_trx  = wr_ok & (paddr == ADDR_TRX);
    wr_ctrl = wr_ok & (paddr == ADDR_CTRL);
    wr_div  = wr_ok & (paddr == ADDR_DIV);
    wr_ss   = wr_ok & (paddr == ADDR_SS);
    // The W1C on STATUS deliberately ignores the transfer lock.
    st_clr  = wr_en & (paddr == ADDR_STATUS) & pwdata[0];
  end

  // Only the low N bits of the register take part in a shift; bits >= N hold.
  always_comb begin
    n_len     = (char_len_q == '0) ? DATA_W : {{(32-CL_W){1'b0}}, char_len_q};
    shl       = {trx_q[DATA_W-2:0], q_miso_q};
    shr       = {1'b0, trx_q[DATA_W-1:1]};
    trx_shift = trx_q;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (i < n_len) begin
        if (lsb_q) begin
          trx_shift[i] = (i == n_len - 1) ? q_miso_q : shr[i];
        end else begin
          trx_shift[i] = shl[i];
        end
      end
    end
  end

  always_comb begin
    char_len_d = char_len_q;
    cpha_d     = cpha_q;
    cpol_d     = cpol_q;
    lsb_d      = lsb_q;
    ie_d       = ie_q;
    ass_d      = ass_q;
    go_bsy_d   = go_bsy_q;
    if (wr_ctrl) begin
      char_len_d = pwdata[CL_W-1:0];
      go_bsy_d   = pwdata[8];
      cpha_d     = pwdata[9];
      cpol_d     = pwdata[10];
      lsb_d      = pwdata[11];
      ie_d       = pwdata[12];
      ass_d      = pwdata[13];
    end else if (bsy_clr) begin
      go_bsy_d = 1'b0;
    end
  end

  always_comb begin
    divider_d  = wr_div ? pwdata[15:0] : divider_q;
    ss_d       = wr_ss ? pwdata[NUM_SS-1:0] : ss_q;
    q_miso_d   = sample_en ? miso_pad_i : q_miso_q;
    int_flag_d = int_flag_q;
    if (bsy_clr) begin
      int_flag_d = 1'b1;
    end else if (st_clr) begin
      int_flag_d = 1'b0;
    end
    trx_d = trx_q;
    if (wr_trx) begin
      trx_d = pwdata[DATA_W-1:0];
    end else if (transfer_en) begin
      trx_d = trx_shift;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      char_len_q <= '0;
      go_bsy_q   <= 1'b0;
      cpha_q     <= 1'b0;
      cpol_q     <= 1'b0;
      lsb_q      <= 1'b0;
      ie_q       <= 1'b0;
      ass_q      <= 1'b0;
      divider_q  <= '1;
      ss_q       <= '0;
      int_flag_q <= 1'b0;
      trx_q      <= '0;
      q_miso_q   <= 1'b0;
    end else begin
      char_len_q <= char_len_d;
      go_bsy_q   <= go_bsy_d;
      cpha_q     <= cpha_d;
      cpol_q     <= cpol_d;
      lsb_q      <= lsb_d;
      ie_q       <= ie_d;
      ass_q      <= ass_d;
      divider_q  <= divider_d;
      ss_q       <= ss_d;
      int_flag_q <= int_flag_d;
      trx_q      <= trx_d;
      q_miso_q   <= q_miso_d;
    end
  end

  always_comb begin
    prdata = '0;
    if (rd_en) begin
      case (paddr)
        ADDR_TRX: prdata[DATA_W-1:0] = trx_q;
        ADDR_CTRL: begin
          prdata[CL_W-1:0] = char_len_q;
          prdata[8]        = go_bsy_q;
          prdata[9]        = cpha_q;
          prdata[10]       = cpol_q;
          prdata[11]       = lsb_q;
          prdata[12]       = ie_q;
          prdata[13]       = ass_q;
        end
        ADDR_DIV:    prdata[15:0] = divider_q;
        ADDR_SS:     prdata[NUM_SS-1:0] = ss_q;
        ADDR_STATUS: prdata[1:0] = {go_bsy_q, int_flag_q};
        default:     prdata = '0;
      endcase
    end
  end

  always_comb begin
    ie       = ie_q;
    lsb      = lsb_q;
    cpol     = cpol_q;
    cpha     = cpha_q;
    go_bsy   = go_bsy_q;
    ass      = ass_q;
    char_len = char_len_q;
    divider  = divider_q;
    trx      = trx_q;
    ss_o     = ass_q ? (ss_q & {NUM_SS{go_bsy_q}}) : ss_q;
    irq      = int_flag_q & ie_q;
  end

endmodule
